// File: rtl/bank_cmd_arbiter.sv
// -----------------------------------------------------------------------------
// bank_cmd_arbiter
//
// Picks at most one bank FSM per cycle and places its command on the single
// DRAM command bus. A bank can only win when its pending command meets the
// DRAM spacing rules: tRCD (ACT -> READ/WRITE, same bank), tRP (PRE -> ACT,
// same bank) and tCCD (READ/WRITE -> READ/WRITE, any bank). Among the banks
// that can go, a round-robin pointer decides who wins. The pointer moves to
// the bank after the last winner.
//
// Ports
//   clk, rst_n  clock; synchronous active-low reset
//   req         per-bank request (the bank is sitting in a *_CHECK state)
//   req_cmd     per-bank command, bits [2i+1:2i]: 0=ACT 1=READ 2=WRITE 3=PRE
//   req_addr    per-bank row (ACT) or column (READ/WRITE) address
//   hold        blocks every new grant (refresh, init); timers keep running
//   stall       combinational, ~grant; a bank moves on when its bit is 0
//   cmd_valid   registered: a command is on the bus this cycle
//   cmd_type    registered: command code, same encoding as req_cmd
//   cmd_bank    registered: bank index of the command
//   cmd_addr    registered: address of the command, 0 for PRE
// -----------------------------------------------------------------------------
module bank_cmd_arbiter #(
    parameter int NUM_BANKS = 8,   // power of two, at least 2
    parameter int ADDR_BITS = 14,
    parameter int T_RCD     = 3,   // 1..31
    parameter int T_RP      = 3,   // 1..31
    parameter int T_CCD     = 2    // 1..31
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic [NUM_BANKS-1:0]           req,
    input  logic [2*NUM_BANKS-1:0]         req_cmd,
    input  logic [ADDR_BITS*NUM_BANKS-1:0] req_addr,
    input  logic                           hold,
    output logic [NUM_BANKS-1:0]           stall,
    output logic                           cmd_valid,
    output logic [1:0]                     cmd_type,
    output logic [$clog2(NUM_BANKS)-1:0]   cmd_bank,
    output logic [ADDR_BITS-1:0]           cmd_addr
);

    localparam int BANK_BITS = $clog2(NUM_BANKS);

    // A counter loaded with T-1 at the grant cycle t reaches 0 at t+T, which
    // is the first cycle the dependent command may be granted.
    localparam logic [4:0] RCD_LOAD = 5'(T_RCD - 1);
    localparam logic [4:0] RP_LOAD  = 5'(T_RP - 1);
    localparam logic [4:0] CCD_LOAD = 5'(T_CCD - 1);

    typedef enum logic [1:0] {
        CMD_ACT   = 2'd0,
        CMD_READ  = 2'd1,
        CMD_WRITE = 2'd2,
        CMD_PRE   = 2'd3
    } cmd_e;

    logic [4:0]           trcd_cnt [NUM_BANKS];
    logic [4:0]           trp_cnt  [NUM_BANKS];
    logic [4:0]           ccd_cnt;
    logic [BANK_BITS-1:0] rr_ptr;

    logic [NUM_BANKS-1:0] eligible;
    logic [NUM_BANKS-1:0] grant;
    logic                 grant_any;
    logic [BANK_BITS-1:0] grant_idx;
    cmd_e                 win_cmd;
    logic [ADDR_BITS-1:0] win_addr;

    // Eligibility. Reset is folded in here so nothing is granted, and every
    // stall bit is high, while rst_n is low.
    always_comb begin
        // NOTE: every bit gets a default before the conditional logic, so no
        // path leaves it unassigned and no latch is inferred.
        eligible = '0;
        for (int i = 0; i < NUM_BANKS; i++) begin
            if (rst_n && !hold && req[i]) begin
                unique case (cmd_e'(req_cmd[2*i +: 2]))
                    CMD_ACT:             eligible[i] = (trp_cnt[i] == '0);
                    CMD_READ, CMD_WRITE: eligible[i] = (trcd_cnt[i] == '0) && (ccd_cnt == '0);
                    CMD_PRE:             eligible[i] = 1'b1;
                endcase
            end
        end
    end

    // Round-robin search: first eligible bank scanning rr_ptr, rr_ptr+1, ...
    // The index wraps by itself because NUM_BANKS is a power of two.
    always_comb begin
        logic [BANK_BITS-1:0] idx;
        grant_any = 1'b0;
        grant_idx = rr_ptr;
        grant     = '0;
        for (int k = 0; k < NUM_BANKS; k++) begin
            idx = rr_ptr + BANK_BITS'(k);
            if (!grant_any && eligible[idx]) begin
                grant_any = 1'b1;
                grant_idx = idx;
            end
        end
        if (grant_any) begin
            grant[grant_idx] = 1'b1;
        end
    end

    assign stall    = ~grant;
    assign win_cmd  = cmd_e'(req_cmd[2*grant_idx +: 2]);
    assign win_addr = req_addr[ADDR_BITS*grant_idx +: ADDR_BITS];

    // Timers, round-robin pointer and command register. A load on a grant
    // wins over the decrement in the same cycle.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            // NOTE: the per-bank timer arrays are reset like any other flop;
            // a stale count across reset would wrongly block a fresh bank.
            for (int i = 0; i < NUM_BANKS; i++) begin
                trcd_cnt[i] <= '0;
                trp_cnt[i]  <= '0;
            end
            ccd_cnt   <= '0;
            rr_ptr    <= '0;
            cmd_valid <= 1'b0;
            cmd_type  <= '0;
            cmd_bank  <= '0;
            cmd_addr  <= '0;
        end else begin
            // NOTE: state updates use non-blocking assignments so every flop
            // samples this cycle's values regardless of statement order.
            for (int i = 0; i < NUM_BANKS; i++) begin
                if (grant[i] && win_cmd == CMD_ACT) begin
                    trcd_cnt[i] <= RCD_LOAD;
                end else if (trcd_cnt[i] != '0) begin
                    trcd_cnt[i] <= trcd_cnt[i] - 5'd1;
                end

                if (grant[i] && win_cmd == CMD_PRE) begin
                    trp_cnt[i] <= RP_LOAD;
                end else if (trp_cnt[i] != '0) begin
                    trp_cnt[i] <= trp_cnt[i] - 5'd1;
                end
            end

            if (grant_any && (win_cmd == CMD_READ || win_cmd == CMD_WRITE)) begin
                ccd_cnt <= CCD_LOAD;
            end else if (ccd_cnt != '0) begin
                ccd_cnt <= ccd_cnt - 5'd1;
            end

            cmd_valid <= grant_any;
            if (grant_any) begin
                rr_ptr   <= grant_idx + BANK_BITS'(1);
                cmd_type <= win_cmd;
                cmd_bank <= grant_idx;
                cmd_addr <= (win_cmd == CMD_PRE) ? '0 : win_addr;
            end
        end
    end

endmodule
